hazard_scoreboard: RTL

//  Parametrised stall generator for the in-order MIPS pipeline (D->E->M->W).

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_scoreboard_if.sv | 52 +++++
 rtl/hazard_scoreboard_mdu_busy_ctr.sv | 37 +++
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard slice: Tnew/Tuse encodings,
// default MDU latencies and the default-geometry scoreboard entry.
package hazard_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2
  } tval_e;

  localparam int unsigned DEF_MULT_LAT = 5;
  localparam int unsigned DEF_DIV_LAT  = 10;

  // Entry layout for the default build (TW=2, DEPTH=3 -> 2-bit age).
  typedef struct packed {
    logic       vld;
    logic [1:0] tnew;
    logic [1:0] age;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard interface: D-stage/issue/MDU request signals toward the
// scoreboard and the stall/busy replies. Stats ports appear only when
// HAZARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
  parameter int unsigned AW   = 5,
  parameter int unsigned NSRC = 2,
  parameter int unsigned TW   = 2
);

  logic                 d_valid;
  logic [NSRC*AW-1:0]   src_addr;
  logic [NSRC*TW-1:0]   src_tuse;
  logic [NSRC-1:0]      src_used;
  logic                 d_hilo;
  logic                 iss_we;
  logic [AW-1:0]        iss_dst;
  logic [TW-1:0]        iss_tnew;
  logic                 md_start;
  logic                 md_div;
  logic                 flush;
  logic                 stall;
  logic                 hilo_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0]          stall_cnt;
  logic [31:0]          hilo_stall_cnt;

  modport master (
    output d_valid, src_addr, src_tuse, src_used, d_hilo,
    output iss_we, iss_dst, iss_tnew, md_start, md_div, flush,
    input  stall, hilo_busy, stall_cnt, hilo_stall_cnt
  );

  modport slave (
    input  d_valid, src_addr, src_tuse, src_used, d_hilo,
    input  iss_we, iss_dst, iss_tnew, md_start, md_div, flush,
    output stall, hilo_busy, stall_cnt, hilo_stall_cnt
  );
`else
  modport master (
    output d_valid, src_addr, src_tuse, src_used, d_hilo,
    output iss_we, iss_dst, iss_tnew, md_start, md_div, flush,
    input  stall, hilo_busy
  );

  modport slave (
    input  d_valid, src_addr, src_tuse, src_used, d_hilo,
    input  iss_we, iss_dst, iss_tnew, md_start, md_div, flush,
    output stall, hilo_busy
  );
`endif

endinterface

// File: rtl/hazard_scoreboard_mdu_busy_ctr.sv
// MDU busy counter: loads the mult or div latency on a start, counts down
// to zero otherwise; busy while non-zero. A clear forces it idle.
module mdu_busy_ctr
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  input  logic clear,
  output logic busy
);

  localparam int unsigned MAXL = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int unsigned CW   = $clog2(MAXL + 1);

  logic [CW-1:0] cnt;

  // Load on start (restart reloads), otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register Tnew scoreboard and stall generator for the D stage of the
// in-order D->E->M->W pipeline, plus HI/LO interlock via mdu_busy_ctr.
// Optional stall statistics counters under HAZARD_STATS_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned TW       = 2,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
  input logic               clk,
  input logic               rst_n,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned AGEW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic            vld;
    logic [TW-1:0]   tnew;
    logic [AGEW-1:0] age;
  } entry_t;

  // Register 0 is never tracked, so the array starts at 1.
  entry_t          sb [1:NREG-1];
  logic [NSRC-1:0] op_stall;
  logic            hilo_busy;
  logic            hilo_stall;
  logic            stall;
  logic            issue;

  mdu_busy_ctr #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (bus.md_start),
    .is_div (bus.md_div),
    .clear  (bus.flush),
    .busy   (hilo_busy)
  );

  // Operand hazard: tracked producer still needs more cycles than the reader allows.
  always_comb begin
    op_stall = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (bus.d_valid && bus.src_used[i] &&
            (bus.src_addr[i*AW +: AW] == AW'(r)) &&
            sb[r].vld && (sb[r].tnew > bus.src_tuse[i*TW +: TW])) begin
          op_stall[i] = 1'b1;
        end
      end
    end
  end

  assign hilo_stall    = bus.d_valid & bus.d_hilo & (hilo_busy | bus.md_start);
  assign stall         = (|op_stall) | hilo_stall;
  assign issue         = bus.d_valid & ~stall & ~bus.flush;
  assign bus.stall     = stall;
  assign bus.hilo_busy = hilo_busy;

  // Scoreboard update: a new issue to a register replaces its entry (also
  // beating a same-edge retire); every other live entry ages and counts Tnew down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 1; r < NREG; r++) sb[r] <= '0;
    end else if (bus.flush) begin
      for (int unsigned r = 1; r < NREG; r++) sb[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (issue && bus.iss_we && (bus.iss_dst == AW'(r))) begin
          sb[r] <= '{vld: 1'b1, tnew: bus.iss_tnew, age: '0};
        end else if (sb[r].vld) begin
          if (sb[r].age == AGEW'(DEPTH - 1)) begin
            sb[r] <= '0;
          end else begin
            sb[r].tnew <= (sb[r].tnew == TW'(T0)) ? sb[r].tnew : sb[r].tnew - 1'b1;
            sb[r].age  <= sb[r].age + 1'b1;
          end
        end
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] hilo_stall_cnt;

  // Free-running stalled-cycle counters; wrap naturally, untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt      <= '0;
      hilo_stall_cnt <= '0;
    end else begin
      if (stall)      stall_cnt      <= stall_cnt + 32'd1;
      if (hilo_stall) hilo_stall_cnt <= hilo_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt      = stall_cnt;
  assign bus.hilo_stall_cnt = hilo_stall_cnt;
`endif

endmodule
